// File: rtl/qerv_bufreg_seq_if.sv
// Control bundle between the instruction state logic and the buffer-register sequencer.
// master drives requests and the bus ack; slave (the sequencer) drives the buffer-register controls.
interface qerv_bufreg_seq_if #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned LB             = $clog2(BITS_PER_CYCLE)
);
    logic        i_start;
    logic        i_mem;
    logic [4:0]  i_shamt;
    logic        i_dbus_ack;
    logic        o_ready;
    logic        o_en;
    logic        o_init;
    logic        o_cnt0;
    logic        o_cnt1;
    logic [LB:0] o_shift_counter_lsb;
    logic        o_dbus_cyc;
    logic        o_done;

    modport master (
        output i_start, i_mem, i_shamt, i_dbus_ack,
        input  o_ready, o_en, o_init, o_cnt0, o_cnt1, o_shift_counter_lsb, o_dbus_cyc, o_done
    );

    modport slave (
        input  i_start, i_mem, i_shamt, i_dbus_ack,
        output o_ready, o_en, o_init, o_cnt0, o_cnt1, o_shift_counter_lsb, o_dbus_cyc, o_done
    );
endinterface

// File: rtl/qerv_bufreg_seq.sv
// Buffer-register sequencer: accumulate pass, then a data-bus phase or a shift pass, then a
// one-cycle done pulse. All outputs decode from registered state only.
module qerv_bufreg_seq #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned LB             = $clog2(BITS_PER_CYCLE)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    qerv_bufreg_seq_if.slave   bus
);

    localparam logic [4:0] Step     = 5'(BITS_PER_CYCLE);
    localparam logic [4:0] LastInit = 5'(32 - BITS_PER_CYCLE);
    localparam logic [4:0] LsbMask  = 5'((1 << LB) - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StMem,
        StShift,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       mem_q, mem_d;
    logic [4:0] shamt_q, shamt_d;

    logic [4:0] shift_beats;
    logic [4:0] beat_idx;

    // Whole-beat part of the shift amount, and the beat index within the shift pass.
    assign shift_beats = shamt_q >> LB;
    assign beat_idx    = cnt_q >> LB;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mem_q   <= 1'b0;
            shamt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            shamt_q <= shamt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        shamt_d = shamt_q;
        case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    mem_d   = bus.i_mem;
                    shamt_d = bus.i_shamt;
                    cnt_d   = '0;
                    state_d = StInit;
                end
            end
            StInit: begin
                cnt_d = cnt_q + Step;
                if (cnt_q == LastInit) begin
                    cnt_d = '0;
                    if (mem_q) begin
                        state_d = StMem;
                    end else if (shift_beats == 5'd0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StMem: begin
                if (bus.i_dbus_ack) begin
                    state_d = StDone;
                end
            end
            StShift: begin
                cnt_d = cnt_q + Step;
                if (beat_idx == shift_beats - 5'd1) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.o_ready             = 1'b0;
        bus.o_en                = 1'b0;
        bus.o_init              = 1'b0;
        bus.o_cnt0              = 1'b0;
        bus.o_cnt1              = 1'b0;
        bus.o_dbus_cyc          = 1'b0;
        bus.o_done              = 1'b0;
        bus.o_shift_counter_lsb = '0;
        if (state_q != StIdle) begin
            bus.o_shift_counter_lsb = (LB + 1)'(shamt_q & LsbMask);
        end
        case (state_q)
            StIdle:  bus.o_ready = 1'b1;
            StInit: begin
                bus.o_en   = 1'b1;
                bus.o_init = 1'b1;
                bus.o_cnt0 = (cnt_q == 5'd0);
                bus.o_cnt1 = (cnt_q == Step);
            end
            StMem:   bus.o_dbus_cyc = 1'b1;
            StShift: bus.o_en = 1'b1;
            StDone:  bus.o_done = 1'b1;
            default: bus.o_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_qerv_bufreg_seq.sv
// Scoreboard bench for qerv_bufreg_seq: stimulus pushes expected per-cycle output vectors,
// a negedge monitor pops and compares them against two instances (1 and 4 bits per beat).
module tb_qerv_bufreg_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qerv_bufreg_seq_if #(.BITS_PER_CYCLE(1)) if1 ();
    qerv_bufreg_seq_if #(.BITS_PER_CYCLE(4)) if4 ();

    qerv_bufreg_seq #(.BITS_PER_CYCLE(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if1.slave)
    );

    qerv_bufreg_seq #(.BITS_PER_CYCLE(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if4.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q1[$];
    logic [9:0] exp_q4[$];

    localparam logic [9:0] IdleVec = 10'h200;

    // Vector layout: ready, en, init, cnt0, cnt1, lsb[2:0], dbus_cyc, done.
    function automatic logic [9:0] pack(logic r, logic e, logic i, logic c0, logic c1,
                                        logic [2:0] l, logic d, logic dn);
        return {r, e, i, c0, c1, l, d, dn};
    endfunction

    function automatic logic [9:0] get_vec(int sel);
        if (sel == 1) begin
            return pack(if1.o_ready, if1.o_en, if1.o_init, if1.o_cnt0, if1.o_cnt1,
                        {2'b00, if1.o_shift_counter_lsb}, if1.o_dbus_cyc, if1.o_done);
        end
        return pack(if4.o_ready, if4.o_en, if4.o_init, if4.o_cnt0, if4.o_cnt1,
                    if4.o_shift_counter_lsb, if4.o_dbus_cyc, if4.o_done);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(int sel, logic s, logic m, logic [4:0] sh, logic a);
        if (sel == 1) begin
            if1.i_start = s; if1.i_mem = m; if1.i_shamt = sh; if1.i_dbus_ack = a;
        end else begin
            if4.i_start = s; if4.i_mem = m; if4.i_shamt = sh; if4.i_dbus_ack = a;
        end
    endtask

    task automatic push_exp(int sel, logic [9:0] v);
        if (sel == 1) exp_q1.push_back(v);
        else exp_q4.push_back(v);
    endtask

    // Expected trace from cycle 1 (first cycle after the start edge); returns its length.
    task automatic push_trace(int sel, int bpc, logic mem, int shamt, int ackd, output int len);
        int n = 32 / bpc;
        int s = shamt / bpc;
        logic [2:0] lsb = 3'(shamt % bpc);
        len = 0;
        for (int k = 1; k <= n; k++) begin
            push_exp(sel, pack(1'b0, 1'b1, 1'b1, k == 1, k == 2, lsb, 1'b0, 1'b0));
            len++;
        end
        if (mem) begin
            for (int j = 0; j <= ackd; j++) begin
                push_exp(sel, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lsb, 1'b1, 1'b0));
                len++;
            end
        end else begin
            for (int j = 0; j < s; j++) begin
                push_exp(sel, pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lsb, 1'b0, 1'b0));
                len++;
            end
        end
        push_exp(sel, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lsb, 1'b0, 1'b1));
        len++;
        for (int j = 0; j < 3; j++) begin
            push_exp(sel, IdleVec);
            len++;
        end
    endtask

    task automatic run_op(int sel, int bpc, logic mem, logic [4:0] shamt, int ackd,
                          logic ack_hold, logic glitch, int exp_done, string name);
        int total;
        int done_cyc = -1;
        int dcount = 0;
        int n = 32 / bpc;
        logic s;
        logic a;
        @(negedge clk);
        drive(sel, 1'b1, mem, shamt, ack_hold);
        @(posedge clk);
        push_trace(sel, bpc, mem, int'(shamt), ackd, total);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            s = glitch && (k == 3 || k == exp_done);
            a = ack_hold || (mem && k == n + 1 + ackd);
            drive(sel, s, mem, shamt, a);
            if (get_vec(sel) & 10'h001) begin
                dcount++;
                if (done_cyc < 0) done_cyc = k;
            end
        end
        drive(sel, 1'b0, 1'b0, 5'd0, 1'b0);
        check({name, "_done_cycle"}, done_cyc, exp_done);
        check({name, "_done_pulses"}, dcount, 1);
    endtask

    always @(negedge clk) begin
        if (exp_q1.size() > 0) check("dut1_trace", int'(get_vec(1)), int'(exp_q1.pop_front()));
        if (exp_q4.size() > 0) check("dut4_trace", int'(get_vec(4)), int'(exp_q4.pop_front()));
    end

    initial begin
        drive(1, 1'b0, 1'b0, 5'd0, 1'b0);
        drive(4, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_hold_dut1", int'(get_vec(1)), int'(IdleVec));
        check("reset_hold_dut4", int'(get_vec(4)), int'(IdleVec));
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_rel_dut1", int'(get_vec(1)), int'(IdleVec));
        check("reset_rel_dut4", int'(get_vec(4)), int'(IdleVec));

        run_op(1, 1, 1'b1, 5'd0, 3, 1'b0, 1'b0, 37, "ls_ack3");
        run_op(1, 1, 1'b0, 5'd5, 0, 1'b1, 1'b0, 38, "shift5");
        run_op(1, 1, 1'b0, 5'd0, 0, 1'b0, 1'b0, 33, "shift0");
        run_op(4, 4, 1'b0, 5'd7, 0, 1'b0, 1'b0, 10, "bpc4_shift7");
        run_op(1, 1, 1'b1, 5'd0, 0, 1'b0, 1'b1, 34, "start_glitch");

        // Asynchronous reset while waiting in the data-bus phase.
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 5'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 5'd0, 1'b0);
        repeat (33) @(negedge clk);
        check("mem_wait_dbus_cyc", int'(if1.o_dbus_cyc), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dbus_cyc", int'(if1.o_dbus_cyc), 0);
        check("async_rst_ready", int'(if1.o_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_vec", int'(get_vec(1)), int'(IdleVec));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
